// File: rtl/phase_pkg.sv
// Shared phase_sequencer types: FSM state encoding and
// phase strobe indices used by the datapath stages.
package phase_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F    = 3'd1,
    S_R    = 3'd2,
    S_X    = 3'd3,
    S_M    = 3'd4,
    S_W    = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam int PH_F   = 0;
  localparam int PH_R   = 1;
  localparam int PH_X   = 2;
  localparam int PH_M   = 3;
  localparam int PH_W   = 4;
  localparam int NUM_PH = 5;

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter with synchronous clear and terminal flag.
// Ports: i_clk, i_rst, i_clr, i_inc in; o_term out (count == WAIT_MAX-1).
module wait_timer #(
  parameter int WAIT_MAX = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  localparam int W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [W-1:0] TERM_V = W'(WAIT_MAX - 1);

  logic [W-1:0] r_cnt;

  // Never counts past TERM_V: a not-ready cycle at the
  // terminal value forces a state change, which clears.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_term = (r_cnt == TERM_V);

endmodule

// File: rtl/phase_sequencer.sv
// Per-instruction phase strobe generator (F,R,X,M,W) with wait states,
// halt, timeout error and cycle/instruction counters.
// Ports: clk, rst, run, imem_ready, dmem_ready, mem_op, hlt_req in;
//        phase_f/r/x/m/w, hlt, err, cycle_cnt, instr_cnt out.
// Build option: PHASE_SKIP_MEM_EN skips M for non-memory instructions.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             mem_op,
  input  logic             hlt_req,
  output logic             phase_f,
  output logic             phase_r,
  output logic             phase_x,
  output logic             phase_m,
  output logic             phase_w,
  output logic             hlt,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t r_state;
  state_t w_next;

  logic [NUM_PH-1:0] w_ph;
  logic              w_wait;
  logic              w_term;
  logic              w_tout;
  logic              w_active;
  logic              r_err;
  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_ins;

  wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_next != r_state),
    .i_inc (w_wait),
    .o_term(w_term)
  );

  always_comb begin
    w_next = r_state;
    w_ph   = '0;
    w_wait = 1'b0;
    w_tout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run) w_next = S_F;
      end
      S_F: begin
        if (imem_ready) begin
          w_next     = S_R;
          w_ph[PH_F] = 1'b1;
        end else begin
          w_wait = 1'b1;
          if (w_term) begin
            w_next = S_HALT;
            w_tout = 1'b1;
          end
        end
      end
      S_R: begin
        w_next     = S_X;
        w_ph[PH_R] = 1'b1;
      end
      S_X: begin
        w_ph[PH_X] = 1'b1;
`ifdef PHASE_SKIP_MEM_EN
        w_next = mem_op ? S_M : S_W;
`else
        w_next = S_M;
`endif
      end
      S_M: begin
        if (!mem_op || dmem_ready) begin
          w_next     = S_W;
          w_ph[PH_M] = 1'b1;
        end else begin
          w_wait = 1'b1;
          if (w_term) begin
            w_next = S_HALT;
            w_tout = 1'b1;
          end
        end
      end
      S_W: begin
        w_ph[PH_W] = 1'b1;
        w_next     = hlt_req ? S_HALT : S_F;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_active = (r_state == S_F) || (r_state == S_R) ||
                    (r_state == S_X) || (r_state == S_M) ||
                    (r_state == S_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_cyc   <= '0;
      r_ins   <= '0;
    end else begin
      r_state <= w_next;
      if (w_tout) r_err <= 1'b1;
      if (w_active) r_cyc <= r_cyc + CNT_W'(1);
      if (r_state == S_W) r_ins <= r_ins + CNT_W'(1);
    end
  end

  assign phase_f   = w_ph[PH_F];
  assign phase_r   = w_ph[PH_R];
  assign phase_x   = w_ph[PH_X];
  assign phase_m   = w_ph[PH_M];
  assign phase_w   = w_ph[PH_W];
  assign hlt       = (r_state == S_HALT);
  assign err       = r_err;
  assign cycle_cnt = r_cyc;
  assign instr_cnt = r_ins;

endmodule
